// File: rtl/countup_pkg.sv
// Shared definitions for the countup elapsed-count timer: state encodings,
// default geometry and the start/stop arbitration helper.
package countup_pkg;

    localparam int unsigned DEF_WIDTH    = 4;
    localparam int unsigned DEF_PRESCALE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // A start request is honoured only when stop is low; stop always wins.
    function automatic logic go_req(input logic start_v, input logic stop_v);
        return start_v && !stop_v;
    endfunction

endpackage

// File: rtl/countup_tick_gen.sv
// Prescaler: counts enabled cycles and flags the cycle on which the phase
// reaches PRESCALE-1, wrapping back to zero on that same edge.
module tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    assign tick = enable && (count_q == TERM);

    // While disabled the phase is frozen so a paused run resumes mid-period.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/countup.sv
// Up-counting elapsed timer with start/stop/clear control, a captured
// terminal count and an optional clock prescaler.
module countup
    import countup_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] counter,
    output logic             running,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] counter_q;
    logic [WIDTH-1:0] limit_q;
    logic             running_q;
    logic             done_q;

    logic             tick;
    logic             presc_en;
    logic             presc_clr;
    logic [WIDTH-1:0] counter_inc;

    assign presc_en    = (state_q == ST_RUN) && !stop;
    assign presc_clr   = clear || (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign counter_inc = counter_q + {{(WIDTH-1){1'b0}}, 1'b1};

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (presc_en),
        .clear  (presc_clr),
        .tick   (tick)
    );

    // running/done are updated alongside every state transition so they
    // stay registered and mutually exclusive.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            limit_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (clear) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    counter_q <= '0;
                    if (go_req(start, stop)) begin
                        limit_q <= limit;
                        if (limit == '0) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                            done_q    <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q   <= ST_HOLD;
                        running_q <= 1'b0;
                    end else if (tick) begin
                        counter_q <= counter_inc;
                        if (counter_inc == limit_q) begin
                            state_q   <= ST_DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (go_req(start, stop)) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    counter_q <= limit_q;
                    running_q <= 1'b0;
                    done_q    <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    counter_q <= '0;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign counter = counter_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_countup.sv
// Directed bench for countup: two instances (PRESCALE 1 and 4) share stimulus;
// each step pushes the expected outputs and checks them after the next edge.
module tb_countup;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] limit = 4'd0;

    logic [3:0] cnt1, cnt4;
    logic       run1, run4, dn1, dn4;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit         which;
        logic [3:0] cnt;
        logic       run;
        logic       dn;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    countup #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .limit(limit), .counter(cnt1), .running(run1), .done(dn1)
    );

    countup #(.WIDTH(4), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .limit(limit), .counter(cnt4), .running(run4), .done(dn4)
    );

    task automatic check_out();
        exp_t       e;
        logic [5:0] obs;
        logic [5:0] expv;
        e    = sb.pop_front();
        obs  = e.which ? {cnt4, run4, dn4} : {cnt1, run1, dn1};
        expv = {e.cnt, e.run, e.dn};
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed cnt=%0d run=%0b done=%0b, expected cnt=%0d run=%0b done=%0b",
                   e.tag, obs[5:2], obs[1], obs[0], expv[5:2], expv[1], expv[0]);
        end
        $display("[TB] %s dut%0d cnt=%0d run=%0b done=%0b", e.tag, e.which ? 4 : 1,
                 obs[5:2], obs[1], obs[0]);
    endtask

    task automatic step(input bit which, input int cnt, input bit run, input bit dn,
                        input string tag);
        exp_t e;
        e.which = which;
        e.cnt   = 4'(cnt);
        e.run   = run;
        e.dn    = dn;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic drive(input bit r, input bit s, input bit p, input bit c, input int l);
        reset = r;
        start = s;
        stop  = p;
        clear = c;
        limit = 4'(l);
    endtask

    task automatic do_reset(input bit which);
        drive(0, 0, 0, 0, 0);
        step(which, 0, 0, 0, "reset_a");
        step(which, 0, 0, 0, "reset_b");
        drive(1, 0, 0, 0, 0);
    endtask

    initial begin
        #1;
        // Basic count to 5 with PRESCALE=1
        do_reset(0);
        drive(1, 1, 0, 0, 5);
        step(0, 0, 1, 0, "p1_enter_run");
        for (int i = 1; i <= 4; i++) step(0, i, 1, 0, "p1_count");
        step(0, 5, 0, 1, "p1_done");
        step(0, 5, 0, 1, "p1_done_hold");
        drive(1, 0, 1, 0, 5);
        step(0, 5, 0, 1, "p1_done_ignores_stop");

        // PRESCALE=4, limit 3: done after 12 RUN cycles
        do_reset(1);
        drive(1, 1, 0, 0, 3);
        step(1, 0, 1, 0, "p4_enter_run");
        for (int i = 1; i <= 12; i++) step(1, i / 4, i < 12, i == 12, "p4_count");

        // Pause mid-period: phase must survive HOLD
        do_reset(1);
        drive(1, 1, 0, 0, 15);
        step(1, 0, 1, 0, "hold_enter_run");
        for (int i = 1; i <= 9; i++) step(1, i / 4, 1, 0, "hold_pre");
        drive(1, 0, 1, 0, 15);
        for (int i = 0; i < 3; i++) step(1, 2, 0, 0, "hold_frozen");
        drive(1, 1, 0, 0, 15);
        step(1, 2, 1, 0, "hold_resume");
        step(1, 2, 1, 0, "hold_phase_2");
        step(1, 2, 1, 0, "hold_phase_3");
        step(1, 3, 1, 0, "hold_tick_3");

        // Zero limit goes straight to DONE
        do_reset(0);
        drive(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, "zero_done");
        step(0, 0, 0, 1, "zero_done_hold");

        // start+stop together, limit change after capture, clear from DONE
        do_reset(0);
        drive(1, 1, 1, 0, 5);
        step(0, 0, 0, 0, "both_idle_a");
        step(0, 0, 0, 0, "both_idle_b");
        drive(1, 1, 0, 0, 5);
        step(0, 0, 1, 0, "cap_enter_run");
        step(0, 1, 1, 0, "cap_count_1");
        drive(1, 1, 1, 0, 5);
        step(0, 1, 0, 0, "both_to_hold");
        step(0, 1, 0, 0, "both_hold_a");
        drive(1, 0, 0, 0, 5);
        step(0, 1, 0, 0, "hold_idle_inputs");
        drive(1, 1, 0, 0, 2);
        step(0, 1, 1, 0, "cap_resume");
        for (int i = 2; i <= 4; i++) step(0, i, 1, 0, "cap_limit_ignored");
        step(0, 5, 0, 1, "cap_done_at_5");
        drive(1, 1, 0, 1, 2);
        step(0, 0, 0, 0, "clear_from_done");
        drive(1, 0, 0, 0, 2);
        step(0, 0, 0, 0, "clear_stays_idle");

        // Reset overrides clear and a running count
        do_reset(0);
        drive(1, 1, 0, 0, 15);
        step(0, 0, 1, 0, "rst_enter_run");
        for (int i = 1; i <= 7; i++) step(0, i, 1, 0, "rst_count");
        drive(0, 1, 0, 1, 15);
        step(0, 0, 0, 0, "rst_mid_run");
        drive(1, 0, 0, 0, 15);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "rst_idle_held");
        drive(1, 1, 0, 0, 15);
        step(0, 0, 1, 0, "rst_restart");
        step(0, 1, 1, 0, "rst_restart_count");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
